// File: rtl/mpc_sram_port.sv
// mpc_sram_port: request/response adapter in front of a one-port synchronous SRAM.
// Requests pass straight through to the SRAM command. Read data returns one
// cycle after the command and is caught in a small response FIFO. Requests are
// throttled so that every accepted read is guaranteed a FIFO slot.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_wdata     request payload (1=write, 0=read)
//   rsp_valid/rsp_ready, rsp_rdata  read response stream, oldest first
//   sram_cs, sram_we, sram_addr,
//   sram_wdata                      SRAM command (combinational pass-through)
//   sram_rdata                      SRAM read data, one cycle after a read
module mpc_sram_port #(
    parameter int ADDR_SIZE = 0,
    parameter int DATA_SIZE = 0,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic                 inflight;
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_SIZE-1:0] mem [RSP_DEPTH];

    logic                 rd_accept;
    logic                 push;
    logic                 pop;
    logic [CNT_W:0]       occ;

    // Wrap modulo RSP_DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots already promised: buffered entries plus the read still in the SRAM.
    // Built from registers only (plus reset), never from rsp_ready or req_valid.
    always_comb begin
        occ       = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        req_ready = ~rst & (occ < (CNT_W + 1)'(RSP_DEPTH));
    end

    // SRAM command pass-through.
    always_comb begin
        sram_cs    = req_valid & req_ready;
        sram_we    = req_we;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
    end

    always_comb begin
        rd_accept = sram_cs & ~req_we;
        push      = inflight;
        rsp_valid = (count != '0);
        pop       = rsp_valid & rsp_ready;
        rsp_rdata = mem[rd_ptr];
    end

    // Control state; reset discards the outstanding read and buffered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= rd_accept;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage, not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sram_rdata;
    end

    // The ready throttle makes a push into a full FIFO unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_mpc_sram_port.sv
module tb_mpc_sram_port;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- depth-4 instance ----------------
    logic       req_valid, req_we, rsp_ready;
    logic [7:0] req_addr, req_wdata;
    logic       req_ready, rsp_valid, sram_cs, sram_we;
    logic [7:0] rsp_rdata, sram_addr, sram_wdata, sram_rdata;

    mpc_sram_port #(.ADDR_SIZE(8), .DATA_SIZE(8), .RSP_DEPTH(4)) u4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM model: unwritten locations read as addr ^ 8'h5A.
    bit       sram_wr [256];
    logic [7:0] sram_mem [256];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                sram_wr[sram_addr]  <= 1'b1;
                sram_mem[sram_addr] <= sram_wdata;
            end else begin
                sram_rdata <= sram_wr[sram_addr] ? sram_mem[sram_addr] : (sram_addr ^ 8'h5A);
            end
        end
    end

    // ---------------- depth-3 instance ----------------
    logic       v3, rr3;
    logic [7:0] a3;
    logic       ready3, rv3, cs3, we3;
    logic [7:0] rd3, sa3, swd3, srd3;

    mpc_sram_port #(.ADDR_SIZE(8), .DATA_SIZE(8), .RSP_DEPTH(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(ready3), .req_we(1'b0),
        .req_addr(a3), .req_wdata(8'h00),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rd3),
        .sram_cs(cs3), .sram_we(we3), .sram_addr(sa3),
        .sram_wdata(swd3), .sram_rdata(srd3)
    );

    always @(posedge clk) begin
        if (cs3 && !we3) srd3 <= sa3 ^ 8'h5A;
    end

    // ---------------- depth-4 scoreboard (samples mid-cycle) ----------------
    bit         ref_wr [256];
    logic [7:0] ref_val [256];
    logic [7:0] exp_q [$];
    int         rsp_cnt = 0;
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_data", 32'(rsp_rdata), 32'(hold_data));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                else check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
            hold_pending = rsp_valid && !rsp_ready;
            hold_data    = rsp_rdata;
            if (req_valid && req_ready) begin
                if (req_we) begin
                    ref_wr[req_addr]  = 1'b1;
                    ref_val[req_addr] = req_wdata;
                end else begin
                    exp_q.push_back(ref_wr[req_addr] ? ref_val[req_addr] : (req_addr ^ 8'h5A));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, n, got, base;
        bit hold3;
        logic [7:0] hd3;

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd0; req_wdata = 8'd0;
        rsp_ready = 1'b0; v3 = 1'b1; a3 = 8'd0; rr3 = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_sram_cs", 32'(sram_cs), 32'd0);
        check("rst_ready3", 32'(ready3), 32'd0);
        rst = 1'b0; req_valid = 1'b0; v3 = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        tick();

        // Write 0xA5 to addr 3, then read it back.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 8'hA5;
        #1;
        check("wr_cs", 32'(sram_cs), 32'd1);
        check("wr_we", 32'(sram_we), 32'd1);
        check("wr_addr", 32'(sram_addr), 32'd3);
        check("wr_wdata", 32'(sram_wdata), 32'hA5);
        tick();
        req_we = 1'b0;
        #1;
        check("rd_cs", 32'(sram_cs), 32'd1);
        check("rd_we", 32'(sram_we), 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check("lat_t1_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(rsp_valid), 32'd1);
        check("lat_t2_data", 32'(rsp_rdata), 32'hA5);
        tick();
        check("lat_t3_valid", 32'(rsp_valid), 32'd0);
        check("one_rsp", 32'(rsp_cnt), 32'd1);

        // Backpressure: reads 0..5 with rsp_ready low; exactly 4 accepted.
        rsp_ready = 1'b0; i = 0; base = rsp_cnt;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(i);
            #1;
            if (c >= 4) check("stall_cs", 32'(sram_cs), 32'd0);
            if (req_ready) i++;
            tick();
        end
        check("stall_accepts", 32'(i), 32'd4);
        check("stall_ready", 32'(req_ready), 32'd0);
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_head", 32'(rsp_rdata), 32'h5A);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && i < 6; c++) begin
            req_valid = 1'b1; req_addr = 8'(i);
            #1;
            if (req_ready) i++;
            tick();
        end
        req_valid = 1'b0;
        check("resume_accepts", 32'(i), 32'd6);
        repeat (6) tick();
        check("stall_drain", 32'(exp_q.size()), 32'd0);
        check("stall_rsp_total", 32'(rsp_cnt - base), 32'd6);

        // Streaming: 16 reads, one per cycle, responses on 16 consecutive cycles.
        base = rsp_cnt;
        for (int k = 0; k < 18; k++) begin
            req_valid = (k < 16); req_we = 1'b0; req_addr = 8'(32 + k);
            #1;
            if (k < 16) check("tp_ready", 32'(req_ready), 32'd1);
            if (k >= 2) check("tp_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        check("tp_idle", 32'(rsp_valid), 32'd0);
        check("tp_rsp_total", 32'(rsp_cnt - base), 32'd16);

        // Toggling rsp_ready during 10 reads.
        n = 0; base = rsp_cnt;
        for (int c = 0; c < 60 && n < 10; c++) begin
            rsp_ready = c[0]; req_valid = 1'b1; req_addr = 8'(64 + n);
            #1;
            if (req_ready) n++;
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) tick();
        check("toggle_accepts", 32'(n), 32'd10);
        check("toggle_drain", 32'(exp_q.size()), 32'd0);
        check("toggle_rsp_total", 32'(rsp_cnt - base), 32'd10);

        // Reset with two responses buffered and one read in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 8'd1; tick();
        req_addr = 8'd2; tick();
        req_valid = 1'b0; tick(); tick();
        req_valid = 1'b1; req_addr = 8'd4;
        #1;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rel_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("rel_no_stale", 32'(rsp_valid), 32'd0);
            tick();
        end
        base = rsp_cnt;
        req_valid = 1'b1; req_addr = 8'd7; tick();
        req_valid = 1'b0; tick();
        check("rel_rd_valid", 32'(rsp_valid), 32'd1);
        check("rel_rd_data", 32'(rsp_rdata), 32'h5D);
        tick();
        check("rel_rd_done", 32'(rsp_valid), 32'd0);
        check("rel_rsp_total", 32'(rsp_cnt - base), 32'd1);

        // Depth-3 wrap: 20 reads with random backpressure, order preserved.
        n = 0; got = 0; hold3 = 1'b0; hd3 = 8'd0;
        for (int c = 0; c < 400 && got < 20; c++) begin
            v3 = (n < 20); a3 = 8'(100 + n); rr3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold3) begin
                check("wrap_hold_valid", 32'(rv3), 32'd1);
                check("wrap_hold_data", 32'(rd3), 32'(hd3));
            end
            if (rv3 && rr3) begin
                check("wrap_data", 32'(rd3), 32'(8'(100 + got) ^ 8'h5A));
                got++;
            end
            hold3 = rv3 && !rr3;
            hd3   = rd3;
            if (v3 && ready3) n++;
            tick();
        end
        v3 = 1'b0;
        check("wrap_accepts", 32'(n), 32'd20);
        check("wrap_rsp_total", 32'(got), 32'd20);
        tick();
        check("wrap_idle", 32'(rv3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
